// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and default width for the bit-serial adder
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/fulladder.sv
// fulladder: one-bit combinational full adder
// ports: a, b, cin -> sum, carry
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one operand bit pair per clock through a single fulladder
// ports: clk, rst_n (async low); start/a/b/cin sampled in IDLE;
//        busy while shifting, done one-cycle pulse, sum/cout held until the next completion
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, sum_q, sum_d, acc_next;
  logic carry_q, carry_d, cout_q, cout_d, done_q, done_d, busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fa_sum, fa_carry, last;
  fulladder u_fa (
    .a     (opa_q[0]),
    .b     (opb_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );
  // new bit enters at the MSB; written as a shift so WIDTH==1 needs no empty slice
  assign acc_next = WIDTH'({fa_sum, acc_q} >> 1);
  assign last     = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_SHIFT;
        opa_d   = a;
        opb_d   = b;
        carry_d = cin;
        cnt_d   = '0;
      end
    end else if (state_q == S_SHIFT) begin
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      acc_d   = acc_next;
      carry_d = fa_carry;
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        state_d = S_DONE;
        sum_d   = acc_next;
        cout_d  = fa_carry;
        done_d  = 1'b1;
      end
    end else begin
      state_d = S_IDLE;
    end
    busy_d = state_d == S_SHIFT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
